// File: rtl/reel_spin_sequencer.sv
// Slot-machine reel sequencer: spins NUM_REELS reels on video frame ticks and
// brings them to rest, in index order, on target symbols latched at spin start.
module reel_spin_sequencer #(
  parameter int NUM_REELS       = 3,
  parameter int SYM_BITS        = 3,
  parameter int NUM_SYMBOLS     = 8,
  parameter int MIN_SPIN_FRAMES = 60,
  parameter int STAGGER_FRAMES  = 30,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_tick,
  input  logic                          start_spin,
  input  logic [NUM_REELS*SYM_BITS-1:0] final_sprites,
  output logic [NUM_REELS*SYM_BITS-1:0] reel_pos,
  output logic [NUM_REELS-1:0]          reel_spinning,
  output logic                          busy,
  output logic                          done
);

  localparam int MAX_THRESH = MIN_SPIN_FRAMES + (NUM_REELS - 1) * STAGGER_FRAMES;
  localparam int FRAME_W    = $clog2(MAX_THRESH + 2);
  localparam int STEP_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [SYM_BITS-1:0] LAST_SYM  = SYM_BITS'(NUM_SYMBOLS - 1);
  localparam logic [SYM_BITS:0]   SYM_LIMIT = (SYM_BITS + 1)'(NUM_SYMBOLS);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [FRAME_W-1:0]  FRAME_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_start_prev;
  logic                 w_start_edge;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic [STEP_W-1:0]    r_step_cnt;
  logic                 w_step;
  logic [NUM_REELS-1:0] r_spinning;
  logic                 r_busy;
  logic                 r_done;
  logic [SYM_BITS-1:0]  r_pos     [NUM_REELS];
  logic [SYM_BITS-1:0]  r_target  [NUM_REELS];
  logic [SYM_BITS-1:0]  w_clamped [NUM_REELS];
  logic [SYM_BITS-1:0]  w_pos_inc [NUM_REELS];
  logic [NUM_REELS-1:0] w_stop;
  logic [NUM_REELS-1:0] w_adv;

  assign w_start_edge = start_spin & ~r_start_prev;
  assign w_step       = (r_state == SPIN) && frame_tick && (r_step_cnt == STEP_LAST);

  // Eligibility looks at the left neighbour's registered state, so at most one
  // reel can come to rest per step and they always stop left to right.
  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    localparam logic [FRAME_W-1:0] THRESH = FRAME_W'(MIN_SPIN_FRAMES + i * STAGGER_FRAMES);
    logic [SYM_BITS-1:0] w_raw;
    logic                w_prev_stopped;
    logic                w_eligible;

    assign w_raw = final_sprites[i*SYM_BITS +: SYM_BITS];
    // Compare one bit wider so NUM_SYMBOLS == 2**SYM_BITS never clamps.
    assign w_clamped[i] = ({1'b0, w_raw} >= SYM_LIMIT) ? LAST_SYM : w_raw;

    if (i == 0) begin : g_first
      assign w_prev_stopped = 1'b1;
    end else begin : g_rest
      assign w_prev_stopped = ~r_spinning[i-1];
    end

    assign w_eligible   = (r_frame_cnt >= THRESH) && w_prev_stopped;
    assign w_stop[i]    = w_step && r_spinning[i] && w_eligible && (r_pos[i] == r_target[i]);
    assign w_adv[i]     = w_step && r_spinning[i] && !w_stop[i];
    assign w_pos_inc[i] = (r_pos[i] == LAST_SYM) ? '0 : r_pos[i] + SYM_BITS'(1);

    assign reel_pos[i*SYM_BITS +: SYM_BITS] = r_pos[i];
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start_edge) w_state_next = SPIN;
      SPIN:    if (r_spinning == '0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: previous start level resets high so a request held through reset is not an edge.
      r_start_prev <= 1'b1;
      r_frame_cnt  <= '0;
      r_step_cnt   <= '0;
      r_spinning   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < NUM_REELS; i++) begin
        r_pos[i]    <= '0;
        r_target[i] <= '0;
      end
    end else begin
      r_start_prev <= start_spin;
      r_busy       <= (w_state_next != IDLE);
      r_done       <= (w_state_next == DONE);

      if ((r_state == IDLE) && w_start_edge) begin
        r_frame_cnt <= '0;
        r_step_cnt  <= '0;
        r_spinning  <= '1;
        for (int i = 0; i < NUM_REELS; i++) r_target[i] <= w_clamped[i];
      end else if ((r_state == SPIN) && frame_tick) begin
        r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + STEP_W'(1);
        if (r_frame_cnt != FRAME_MAX) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        for (int i = 0; i < NUM_REELS; i++) begin
          if (w_stop[i]) r_spinning[i] <= 1'b0;
          if (w_adv[i])  r_pos[i]      <= w_pos_inc[i];
        end
      end
    end
  end

  assign reel_spinning = r_spinning;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_reel_spin_sequencer.sv
// Bench for reel_spin_sequencer: a lockstep reel model feeds an expectation
// queue per frame tick; a second instance covers clamping and slow stepping.
`timescale 1ns/1ps
module tb_reel_spin_sequencer;

  localparam int NR   = 3;
  localparam int NS   = 8;
  localparam int MINF = 4;
  localparam int STAG = 2;
  localparam int FPS  = 1;

  typedef struct {
    logic [8:0] pos;
    logic [2:0] spin;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       a_tick, a_start, a_busy, a_done;
  logic [8:0] a_final, a_pos;
  logic [2:0] a_spin;
  logic       b_tick, b_start, b_busy, b_done;
  logic [2:0] b_final, b_pos;
  logic [0:0] b_spin;

  int checks = 0;
  int errors = 0;

  exp_t a_q[$];
  exp_t b_q[$];

  int m_pos [NR];
  int m_tgt [NR];
  bit m_spin[NR];
  int m_frame;
  int m_step;
  int last_stop[NR];

  reel_spin_sequencer #(
    .NUM_REELS(NR), .SYM_BITS(3), .NUM_SYMBOLS(NS),
    .MIN_SPIN_FRAMES(MINF), .STAGGER_FRAMES(STAG), .FRAMES_PER_STEP(FPS)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .frame_tick(a_tick), .start_spin(a_start),
    .final_sprites(a_final), .reel_pos(a_pos), .reel_spinning(a_spin),
    .busy(a_busy), .done(a_done)
  );

  reel_spin_sequencer #(
    .NUM_REELS(1), .SYM_BITS(3), .NUM_SYMBOLS(6),
    .MIN_SPIN_FRAMES(MINF), .STAGGER_FRAMES(STAG), .FRAMES_PER_STEP(3)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .frame_tick(b_tick), .start_spin(b_start),
    .final_sprites(b_final), .reel_pos(b_pos), .reel_spinning(b_spin),
    .busy(b_busy), .done(b_done)
  );

  function automatic logic [8:0] model_pos_vec();
    logic [8:0] v;
    for (int i = 0; i < NR; i++) v[i*3 +: 3] = 3'(m_pos[i]);
    return v;
  endfunction

  function automatic logic [2:0] model_spin_vec();
    logic [2:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_spin[i];
    return v;
  endfunction

  function automatic bit model_busy();
    return (model_spin_vec() != 3'b000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_pos[i] = 0; m_tgt[i] = 0; m_spin[i] = 1'b0;
    end
    m_frame = 0;
    m_step  = 0;
  endtask

  task automatic model_start(input logic [8:0] tg);
    for (int i = 0; i < NR; i++) begin
      m_tgt[i]  = (int'(tg[i*3 +: 3]) >= NS) ? NS - 1 : int'(tg[i*3 +: 3]);
      m_spin[i] = 1'b1;
    end
    m_frame = 0;
    m_step  = 0;
  endtask

  task automatic model_tick();
    bit   step;
    bit   prev[NR];
    bit   left_stopped;
    exp_t e;
    step   = (m_step == FPS - 1);
    m_step = step ? 0 : m_step + 1;
    prev   = m_spin;
    left_stopped = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (step && prev[i]) begin
        if (m_frame >= MINF + i * STAG && left_stopped && m_pos[i] == m_tgt[i]) m_spin[i] = 1'b0;
        else m_pos[i] = (m_pos[i] + 1) % NS;
      end
      left_stopped = !prev[i];
    end
    m_frame++;
    e.pos  = model_pos_vec();
    e.spin = model_spin_vec();
    a_q.push_back(e);
  endtask

  task automatic start_a(input logic [8:0] tg, input logic with_tick);
    @(negedge clk);
    a_final = tg;
    a_start = 1'b1;
    a_tick  = with_tick;
    model_start(tg);
    @(negedge clk);
    a_start = 1'b0;
    a_tick  = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_spin !== 3'b111 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: busy=%b spin=%b done=%b, wanted busy=1 spin=111 done=0",
               a_busy, a_spin, a_done);
    end
  endtask

  task automatic tick_and_compare_a(input string name, input int k);
    exp_t e;
    @(negedge clk);
    a_tick = 1'b1;
    model_tick();
    @(negedge clk);
    a_tick = 1'b0;
    e = a_q.pop_front();
    checks++;
    if (a_pos !== e.pos || a_spin !== e.spin) begin
      errors++;
      $display("FAIL %s tick %0d: pos=%h spin=%b, wanted pos=%h spin=%b",
               name, k, a_pos, a_spin, e.pos, e.spin);
    end
  endtask

  task automatic run_a(input string name, input bit disturb);
    logic [2:0] prev_spin;
    int k, done_cnt, done_first;
    for (int i = 0; i < NR; i++) last_stop[i] = -1;
    prev_spin = a_spin;
    done_cnt  = 0;
    k         = 0;
    while (model_busy() && k < 300) begin
      if (disturb && k == 5) begin a_start = 1'b1; a_final = 9'h0AB; end
      if (disturb && k == 7) a_start = 1'b0;
      tick_and_compare_a(name, k);
      if (a_done === 1'b1) done_cnt++;
      for (int i = 0; i < NR; i++) if (prev_spin[i] && !a_spin[i]) last_stop[i] = k;
      prev_spin = a_spin;
      k++;
    end
    if (model_busy()) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still spinning after %0d ticks", name, k);
    end
    done_first = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_done === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
      end
    end
    checks++;
    if (done_cnt != 1 || done_first != 0) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d first_at=%0d, wanted pulses=1 first_at=0",
               name, done_cnt, done_first);
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: busy=%b, wanted 0", name, a_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (a_pos !== 9'h000 || a_spin !== 3'b000 || a_busy !== 1'b0 || a_done !== 1'b0 ||
        b_pos !== 3'h0 || b_spin !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: a pos=%h spin=%b busy=%b done=%b b pos=%h, wanted all 0",
               a_pos, a_spin, a_busy, a_done, b_pos);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // start_spin is still high: no spin may begin while it stays high.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_tick = ~a_tick;
    end
    a_tick = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_spin !== 3'b000 || a_pos !== 9'h000) begin
      errors++;
      $display("FAIL start_held_reset: busy=%b spin=%b pos=%h, wanted 0 000 000",
               a_busy, a_spin, a_pos);
    end
    a_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_a(9'h000, 1'b1);
    run_a("basic", 1'b0);
    checks++;
    if (last_stop[0] != 8 || last_stop[1] != 16 || last_stop[2] != 24) begin
      errors++;
      $display("FAIL basic_stop_ticks: %0d %0d %0d, wanted 8 16 24",
               last_stop[0], last_stop[1], last_stop[2]);
    end
  endtask

  task automatic test_wrap_persist();
    logic [8:0] held;
    start_a({3'd5, 3'd3, 3'd7}, 1'b0);
    run_a("wrap1", 1'b0);
    checks++;
    if (a_pos !== {3'd5, 3'd3, 3'd7}) begin
      errors++;
      $display("FAIL wrap1_final: pos=%h, wanted %h", a_pos, {3'd5, 3'd3, 3'd7});
    end
    held = a_pos;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); a_tick = 1'b1;
      @(negedge clk); a_tick = 1'b0;
    end
    checks++;
    if (a_pos !== {3'd5, 3'd3, 3'd7} || a_busy !== 1'b0 || a_spin !== 3'b000) begin
      errors++;
      $display("FAIL idle_ticks: pos=%h busy=%b spin=%b, wanted %h 0 000",
               a_pos, a_busy, a_spin, held);
    end
    start_a({3'd2, 3'd2, 3'd2}, 1'b0);
    run_a("wrap2", 1'b0);
    checks++;
    if (a_pos !== {3'd2, 3'd2, 3'd2}) begin
      errors++;
      $display("FAIL wrap2_final: pos=%h, wanted %h", a_pos, {3'd2, 3'd2, 3'd2});
    end
  endtask

  task automatic test_ignored_start();
    start_a({3'd1, 3'd6, 3'd4}, 1'b0);
    run_a("ignored", 1'b1);
    checks++;
    if (a_pos !== {3'd1, 3'd6, 3'd4}) begin
      errors++;
      $display("FAIL ignored_final: pos=%h, wanted %h", a_pos, {3'd1, 3'd6, 3'd4});
    end
  endtask

  task automatic test_reset_mid_spin();
    int done_seen;
    start_a({3'd3, 3'd3, 3'd3}, 1'b0);
    for (int k = 0; k < 10; k++) tick_and_compare_a("pre_reset", k);
    @(negedge clk);
    a_tick  = 1'b1;
    a_start = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_pos !== 9'h000 || a_spin !== 3'b000 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: pos=%h spin=%b busy=%b done=%b, wanted all 0",
               a_pos, a_spin, a_busy, a_done);
    end
    a_q.delete();
    model_reset();
    done_seen = 0;
    repeat (2) @(negedge clk);
    a_tick  = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_tick = ~a_tick;
      if (a_done === 1'b1 || a_busy === 1'b1) done_seen++;
    end
    a_tick = 1'b0;
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: busy/done seen %0d times, wanted 0", done_seen);
    end
    a_start = 1'b0;
    @(negedge clk);
    start_a({3'd6, 3'd0, 3'd2}, 1'b0);
    run_a("after_reset", 1'b0);
    checks++;
    if (a_pos !== {3'd6, 3'd0, 3'd2}) begin
      errors++;
      $display("FAIL after_reset_final: pos=%h, wanted %h", a_pos, {3'd6, 3'd0, 3'd2});
    end
  endtask

  task automatic test_clamp_step_rate();
    exp_t e, got;
    int   st, done_cnt;
    bit   fin;
    @(negedge clk);
    b_final = 3'd7;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    checks++;
    if (b_busy !== 1'b1 || b_spin !== 1'b1) begin
      errors++;
      $display("FAIL clamp_accept: busy=%b spin=%b, wanted 1 1", b_busy, b_spin);
    end
    fin = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      b_tick = 1'b1;
      st     = (k + 1) / 3;
      e.pos  = 9'((st > 5) ? 5 : st);
      e.spin = (k < 17) ? 3'd1 : 3'd0;
      b_q.push_back(e);
      fin = (k >= 17);
      @(negedge clk);
      b_tick = 1'b0;
      got = b_q.pop_front();
      checks++;
      if ({6'd0, b_pos} !== got.pos || {2'd0, b_spin} !== got.spin) begin
        errors++;
        $display("FAIL clamp tick %0d: pos=%0d spin=%b, wanted pos=%0d spin=%b",
                 k, b_pos, b_spin, got.pos, got.spin[0]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (b_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 1 || b_busy !== 1'b0 || b_pos !== 3'd5) begin
      errors++;
      $display("FAIL clamp_end: done pulses=%0d busy=%b pos=%0d, wanted 1 0 5",
               done_cnt, b_busy, b_pos);
    end
  endtask

  initial begin
    a_tick  = 1'b0; a_start = 1'b1; a_final = '0;
    b_tick  = 1'b0; b_start = 1'b0; b_final = '0;
    model_reset();
    test_reset();
    test_basic();
    test_wrap_persist();
    test_ignored_start();
    test_reset_mid_spin();
    test_clamp_step_rate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
